// File: rtl/bist_pkg.sv
// Shared types and the Galois step used by the BIST pattern driver.
// Both the stimulus LFSR and the response MISR advance with galois_step.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] galois_step(
    input logic [15:0] l
  );
    return {1'b0, l[15:1]} ^ (l[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register compacting CUT responses.
// Cleared at run start, advanced only on capture cycles.
module bist_misr
  import bist_pkg::*;
#(
  parameter int OUT_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [OUT_W-1:0] din,
  output logic [15:0]      sig
);

  logic [15:0] misr_d;
  logic [15:0] misr_q;

  // next signature: clear wins, otherwise fold in the zero-extended response
  always_comb begin
    misr_d = misr_q;
    if (clr) begin
      misr_d = '0;
    end else if (en) begin
      misr_d = galois_step(misr_q) ^ 16'(din);
    end
  end

  // signature register, dropped to zero on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misr_q <= '0;
    end else begin
      misr_q <= misr_d;
    end
  end

  assign sig = misr_q;

endmodule

// File: rtl/bist_pattern_driver.sv
// LFSR stimulus, CUT reset control and MISR signature check for one CUT.
// Response for vector j is captured SETTLE cycles after it is applied.
module bist_pattern_driver
  import bist_pkg::*;
#(
  parameter int          IN_W          = 15,
  parameter int          OUT_W         = 13,
  parameter int          PATTERN_COUNT = 256,
  parameter int          SETTLE        = 2,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic             start,
  input  logic [15:0]      golden_sig,
  input  logic [OUT_W-1:0] cut_out,
  output logic [IN_W-1:0]  cut_in,
  output logic             cut_reset,
  output logic             busy,
  output logic             done,
  output logic [15:0]      signature,
  output logic             pass
);

  localparam int CW = $clog2(PATTERN_COUNT + SETTLE + 1);

  localparam logic [15:0] SEED =
    (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  localparam logic [CW-1:0] LAST_RUN = CW'(PATTERN_COUNT - 1);
  localparam logic [CW-1:0] LAST_ALL =
    CW'(PATTERN_COUNT + SETTLE - 1);
  localparam logic [CW-1:0] CAP_FROM = CW'(SETTLE);
  localparam logic [CW-1:0] INIT_END = CW'(1);

  state_e          state_d;
  state_e          state_q;
  logic [CW-1:0]   cnt_d;
  logic [CW-1:0]   cnt_q;
  logic [15:0]     lfsr_d;
  logic [15:0]     lfsr_q;
  logic            misr_clr;
  logic            misr_en;

  logic [IN_W-1:0] cut_in_d;
  logic [IN_W-1:0] cut_in_q;
  logic            cut_reset_d;
  logic            cut_reset_q;
  logic            busy_d;
  logic            busy_q;
  logic            done_d;
  logic            done_q;
  logic            drive_d;

  // sequencing: cnt is the INIT timer, then one global RUN+DRAIN index
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lfsr_d   = lfsr_q;
    misr_clr = 1'b0;
    misr_en  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = INIT;
          cnt_d    = '0;
          lfsr_d   = SEED;
          misr_clr = 1'b1;
        end
      end
      INIT: begin
        if (cnt_q == INIT_END) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        misr_en = (cnt_q >= CAP_FROM);
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_RUN) begin
          state_d = (SETTLE == 0) ? DONE : DRAIN;
        end else begin
          lfsr_d = galois_step(lfsr_q);
        end
      end
      DRAIN: begin
        misr_en = (cnt_q >= CAP_FROM);
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_ALL) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // output decode from the next state so outputs leave flops
  always_comb begin
    drive_d     = (state_d == RUN) || (state_d == DRAIN);
    cut_in_d    = drive_d ? lfsr_d[IN_W-1:0] : '0;
    cut_reset_d = !drive_d;
    busy_d      = drive_d || (state_d == INIT);
    done_d      = (state_q == DONE) && (state_d == DONE);
  end

  // FSM, LFSR and registered outputs
  always_ff @(posedge blif_clk_net or posedge blif_reset_net) begin
    if (blif_reset_net) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lfsr_q      <= SEED;
      cut_in_q    <= '0;
      cut_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      cut_in_q    <= cut_in_d;
      cut_reset_q <= cut_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  bist_misr #(
    .OUT_W (OUT_W)
  ) u_misr (
    .clk (blif_clk_net),
    .rst (blif_reset_net),
    .clr (misr_clr),
    .en  (misr_en),
    .din (cut_out),
    .sig (signature)
  );

  assign cut_in    = cut_in_q;
  assign cut_reset = cut_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = done_q && (signature == golden_sig);

endmodule

// File: tb/tb_bist_pattern_driver.sv
// Directed bench for bist_pattern_driver.
// Four instances cover default, P=1/S=0, seed 0 and SETTLE>=P.
module tb_bist_pattern_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic        rst_a;
  logic        start_a;
  logic [15:0] golden_a;
  logic [12:0] cut_out_a;
  logic [14:0] cut_in_a;
  logic        cut_reset_a;
  logic        busy_a;
  logic        done_a;
  logic [15:0] sig_a;
  logic        pass_a;

  logic        rst_b;
  logic        start_b;

  logic [14:0] cut_in_p1;
  logic        cut_reset_p1;
  logic        busy_p1;
  logic        done_p1;
  logic [15:0] sig_p1;
  logic        pass_p1;

  logic [14:0] cut_in_s;
  logic        cut_reset_s;
  logic        busy_s;
  logic        done_s;
  logic [15:0] sig_s;
  logic        pass_s;

  logic [14:0] cut_in_p2;
  logic        cut_reset_p2;
  logic        busy_p2;
  logic        done_p2;
  logic [15:0] sig_p2;
  logic        pass_p2;

  bist_pattern_driver u_dut (
    .blif_clk_net   (clk),
    .blif_reset_net (rst_a),
    .start          (start_a),
    .golden_sig     (golden_a),
    .cut_out        (cut_out_a),
    .cut_in         (cut_in_a),
    .cut_reset      (cut_reset_a),
    .busy           (busy_a),
    .done           (done_a),
    .signature      (sig_a),
    .pass           (pass_a)
  );

  bist_pattern_driver #(
    .PATTERN_COUNT (1),
    .SETTLE        (0)
  ) u_p1 (
    .blif_clk_net   (clk),
    .blif_reset_net (rst_b),
    .start          (start_b),
    .golden_sig     (16'h0001),
    .cut_out        (13'h0001),
    .cut_in         (cut_in_p1),
    .cut_reset      (cut_reset_p1),
    .busy           (busy_p1),
    .done           (done_p1),
    .signature      (sig_p1),
    .pass           (pass_p1)
  );

  bist_pattern_driver #(
    .LFSR_SEED (16'h0000)
  ) u_s0 (
    .blif_clk_net   (clk),
    .blif_reset_net (rst_b),
    .start          (start_b),
    .golden_sig     (16'h0000),
    .cut_out        (13'h0000),
    .cut_in         (cut_in_s),
    .cut_reset      (cut_reset_s),
    .busy           (busy_s),
    .done           (done_s),
    .signature      (sig_s),
    .pass           (pass_s)
  );

  bist_pattern_driver #(
    .PATTERN_COUNT (2),
    .SETTLE        (3)
  ) u_p2 (
    .blif_clk_net   (clk),
    .blif_reset_net (rst_b),
    .start          (start_b),
    .golden_sig     (16'hB402),
    .cut_out        (13'h0003),
    .cut_in         (cut_in_p2),
    .cut_reset      (cut_reset_p2),
    .busy           (busy_p2),
    .done           (done_p2),
    .signature      (sig_p2),
    .pass           (pass_p2)
  );

  function automatic logic [15:0] tb_step(input logic [15:0] x);
    logic [15:0] r;
    r = x >> 1;
    if (x[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic logic [15:0] misr_model(
    input logic [15:0] c,
    input int          n
  );
    logic [15:0] m;
    m = 16'h0000;
    for (int i = 0; i < n; i++) m = tb_step(m) ^ c;
    return m;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic pulse_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    cyc = 0;
  endtask

  task automatic run_a(
    input  logic [12:0] c,
    input  bit          poke,
    output int          lat
  );
    logic [15:0] v;
    cut_out_a = c;
    pulse_a();
    chk("init0_busy", busy_a, 1);
    chk("init0_cut_reset", cut_reset_a, 1);
    step();
    chk("init1_cut_reset", cut_reset_a, 1);
    step();
    chk("run0_cut_reset", cut_reset_a, 0);
    chk("run0_cut_in", cut_in_a, 15'h2CE1);
    v = 16'hACE1;
    for (int k = 0; k < 256; k++) begin
      chk("run_cut_in", cut_in_a, v[14:0]);
      if (k < 255) v = tb_step(v);
      start_a = poke && (k == 10);
      step();
    end
    start_a = 1'b0;
    chk("drain_cut_in", cut_in_a, v[14:0]);
    chk("drain_busy", busy_a, 1);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (done_a) begin
        lat = cyc;
        break;
      end
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    int          lat_p1;
    int          lat_p2;
    int          lat_s;
    logic [15:0] exp_sig;
    logic [15:0] vs;

    rst_a     = 1'b1;
    rst_b     = 1'b1;
    start_a   = 1'b0;
    start_b   = 1'b0;
    golden_a  = 16'h0000;
    cut_out_a = 13'h0000;
    repeat (2) @(negedge clk);

    chk("rst_cut_reset", cut_reset_a, 1);
    chk("rst_cut_in", cut_in_a, 0);
    chk("rst_sig", sig_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);

    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_busy", busy_a, 0);
    chk("idle_cut_reset", cut_reset_a, 1);

    run_a(13'h0000, 1'b0, lat);
    chk("run1_latency", lat, 261);
    chk("run1_sig", sig_a, 16'h0000);
    chk("run1_busy", busy_a, 0);
    chk("run1_cut_reset", cut_reset_a, 1);
    chk("run1_cut_in", cut_in_a, 0);
    golden_a = 16'h0000;
    #1;
    chk("run1_pass_g0", pass_a, 1);
    golden_a = 16'h0001;
    #1;
    chk("run1_pass_g1", pass_a, 0);
    @(negedge clk);

    exp_sig = misr_model(16'h1A5B, 256);
    run_a(13'h1A5B, 1'b1, lat);
    chk("run2_latency", lat, 261);
    chk("run2_sig", sig_a, exp_sig);
    golden_a = exp_sig;
    #1;
    chk("run2_pass", pass_a, 1);
    @(negedge clk);

    run_a(13'h1A5B, 1'b0, lat);
    chk("run3_latency", lat, 261);
    chk("run3_sig", sig_a, exp_sig);
    repeat (5) step();
    chk("done_hold_sig", sig_a, exp_sig);
    chk("done_hold_done", done_a, 1);

    cut_out_a = 13'h1A5B;
    pulse_a();
    while (cyc < 60) step();
    chk("mid_sig", sig_a, misr_model(16'h1A5B, 56));
    #2;
    rst_a = 1'b1;
    #1;
    chk("abort_cut_reset", cut_reset_a, 1);
    chk("abort_cut_in", cut_in_a, 0);
    chk("abort_sig", sig_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    @(negedge clk);
    rst_a = 1'b0;
    repeat (4) step();
    chk("post_abort_busy", busy_a, 0);
    chk("post_abort_cut_reset", cut_reset_a, 1);
    chk("post_abort_sig", sig_a, 0);

    lat_p1 = -1;
    lat_p2 = -1;
    lat_s  = -1;
    vs     = 16'h0001;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    cyc = 0;
    for (int i = 0; i < 300; i++) begin
      if (cyc >= 2 && cyc < 258) begin
        chk("s0_cut_in", cut_in_s, vs[14:0]);
        vs = tb_step(vs);
      end
      if (cyc == 2) chk("p1_run0_cut_in", cut_in_p1, 15'h2CE1);
      if (cyc == 2) chk("s0_first_vec", cut_in_s, 15'h0001);
      if (done_p1 && lat_p1 < 0) lat_p1 = cyc;
      if (done_p2 && lat_p2 < 0) lat_p2 = cyc;
      if (done_s && lat_s < 0) lat_s = cyc;
      step();
    end
    chk("p1_latency", lat_p1, 4);
    chk("p1_sig", sig_p1, 16'h0001);
    chk("p1_pass", pass_p1, 1);
    chk("p2_latency", lat_p2, 8);
    chk("p2_sig", sig_p2, misr_model(16'h0003, 2));
    chk("p2_sig_hand", sig_p2, 16'hB402);
    chk("p2_pass", pass_p2, 1);
    chk("s0_latency", lat_s, 261);
    chk("s0_sig", sig_s, 16'h0000);
    chk("s0_pass", pass_s, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bist_pattern_driver.md
Name: bist_pattern_driver

Overview:
- Self-test harness for the other end of a generated circuit-under-test (CUT), such as the merged ISCAS-style pattern netlists.
- Drives the CUT's primary inputs with LFSR pseudo-random vectors and compacts the CUT's primary outputs into a MISR signature.
- Controls the CUT's own reset and compares the final signature against a golden value.
- Sits beside one CUT instance on the same clock, under a top-level test wrapper.

Parameters:
- IN_W, 15, CUT primary-input width (≤16).
- OUT_W, 13, CUT primary-output width (≤16).
- PATTERN_COUNT, 256, number of vectors applied and captured (≥1).
- SETTLE, 2, CUT pipeline depth in cycles between a vector being applied and its response being captured (≥0).
- LFSR_SEED, 16'hACE1, LFSR start value; zero is illegal and is replaced by 16'h0001.

Ports:
- blif_clk_net  in  1  clock, rising edge.
- blif_reset_net  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a run when in IDLE or DONE.
- golden_sig  in  16  expected signature, sampled in DONE.
- cut_out  in  OUT_W  CUT primary outputs.
- cut_in  out  IN_W  CUT primary inputs.
- cut_reset  out  1  active-high reset to the CUT.
- busy  out  1  high in INIT, RUN and DRAIN.
- done  out  1  high in DONE.
- signature  out  16  MISR contents.
- pass  out  1  done && (signature == golden_sig).

Behaviour:
- Reset (asynchronous) gives: state=IDLE, lfsr=seed, misr=0, counters=0, cut_in=0, cut_reset=1, busy=0, done=0, pass=0.
- Reset asserted mid-run aborts the run immediately to these values; no partial signature is kept.
- LFSR: 16-bit Galois, right shift, taps 16'hB400.
  - Next value = {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 0).
  - cut_in = lfsr[IN_W-1:0] in RUN and DRAIN; 0 otherwise.
- MISR: same step function, then XOR with cut_out zero-extended to 16 bits. It updates only on capture cycles.
- States and transitions:
  - IDLE: cut_reset=1. On start: lfsr←seed, misr←0, go to INIT.
  - INIT: holds exactly 2 cycles with cut_reset=1, then goes to RUN with cut_reset=0.
  - RUN: PATTERN_COUNT cycles; lfsr steps every cycle.
    - Cycle index k (0-based) applies vector k.
    - Capture happens when k ≥ SETTLE.
    - After the last RUN cycle, go to DRAIN, or straight to DONE if SETTLE=0.
  - DRAIN: SETTLE cycles; lfsr frozen on the last vector; capture every cycle; then go to DONE.
  - DONE: signature held, done=1, cut_reset=1. On start: restart exactly as from IDLE.
- Capture count is exactly PATTERN_COUNT in every configuration.
  - If SETTLE ≥ PATTERN_COUNT, all captures fall in DRAIN.
- start while busy is ignored.
- start on the same edge as a state exit is ignored unless the current state is IDLE or DONE.
- Counters are sized $clog2(PATTERN_COUNT+SETTLE+1) and never wrap within a run.
- Latency from the start pulse to done is 2 + PATTERN_COUNT + SETTLE cycles, then +1 for the DONE register.
- pass is combinational from the registered signature and done.

Decomposition:
- Package bist_pkg contains:
  - state enum {IDLE, INIT, RUN, DRAIN, DONE}
  - LFSR_TAPS=16'hB400
  - function galois_step(logic [15:0]) returning logic [15:0]
- The LFSR and MISR both use galois_step.
- One natural sub-module: bist_misr, holding the MISR register, enable and zero-extension.
- The FSM and LFSR stay in the top module.

Test Plan:
- Assert reset mid-sequence → within the same cycle: cut_reset=1, cut_in=0, signature=0, busy=0, done=0. After release the block stays IDLE.
- start with the default seed → cut_in=15'h2CE1 on RUN cycle 0 and 15'h6270 on RUN cycle 1. cut_reset is 1 for the 2 INIT cycles, then 0.
- cut_out held at 0, PATTERN_COUNT=256, SETTLE=2 → done rises 261 cycles after start; signature=16'h0000; pass=1 with golden_sig=0 and pass=0 with golden_sig=1.
- PATTERN_COUNT=1, SETTLE=0, cut_out=13'h0001 → exactly 1 capture; signature=16'h0001; done after 4 cycles.
- start pulsed during RUN → ignored; capture count is unchanged. start in DONE → new run; misr is cleared; with identical stimulus the same signature is reproduced.
- LFSR_SEED=0 → first vector = 15'h0001; the LFSR never sticks at 0 across 256 steps.
